// File: rtl/alisim_pkg.sv
// Shared types and constants for the alignment-simulation pipeline:
// nucleotide codes, probability widths, sampler FSM states and LFSR settings.
package alisim_pkg;

  localparam int PROB_W = 10;
  localparam int ROW_W  = 4 * PROB_W;

  typedef enum logic [1:0] {
    NUC_A = 2'b00,
    NUC_C = 2'b01,
    NUC_G = 2'b10,
    NUC_T = 2'b11
  } nucl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // An all-zero state would lock the LFSR, so it is never allowed in.
  function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/nucl_lfsr16.sv
// 16-bit Galois LFSR with synchronous reload; zero seeds are replaced by the
// default seed both at reset and on load.
module nucl_lfsr16
  import alisim_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  localparam logic [15:0] RESET_VAL = lfsr_seed_fix(SEED);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= lfsr_seed_fix(load_val);
    end else if (en) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/nucl_sampler.sv
// Per-site inverse-CDF nucleotide sampler: latches one chunk of probability
// rows, draws one LFSR value per site and packs the chosen 2-bit codes.
module nucl_sampler #(
  parameter int          N_SITES = 16,
  parameter int          PROB_W  = 10,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_SITES*4*PROB_W-1:0] in_rows,
  input  logic                        seed_load,
  input  logic [15:0]                 seed,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*N_SITES-1:0]        out_nucl,
  output logic                        busy
);

  import alisim_pkg::state_e;
  import alisim_pkg::IDLE;
  import alisim_pkg::RUN;
  import alisim_pkg::DONE;
  import alisim_pkg::nucl_e;
  import alisim_pkg::NUC_A;
  import alisim_pkg::NUC_C;
  import alisim_pkg::NUC_G;
  import alisim_pkg::NUC_T;

  localparam int ROW_W = 4 * PROB_W;
  localparam int CNT_W = (N_SITES > 1) ? $clog2(N_SITES) : 1;
  localparam int SUM_W = PROB_W + 2;
  localparam logic [CNT_W-1:0] LAST_SITE = CNT_W'(N_SITES - 1);

  state_e                     state_q, state_d;
  logic [N_SITES*ROW_W-1:0]   rows_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [2*N_SITES-1:0]       nucl_q;
  logic [15:0]                lfsr_q;

  logic [ROW_W-1:0]           row;
  logic [SUM_W-1:0]           c0, c1, c2, r;
  nucl_e                      pick;

  nucl_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state_q == RUN),
    .load     ((state_q == IDLE) && seed_load),
    .load_val (seed),
    .q        (lfsr_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)            state_d = RUN;
      RUN:     if (cnt_q == LAST_SITE)  state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Cumulative thresholds are widened so oversubscribed rows saturate
  // toward earlier symbols instead of wrapping.
  always_comb begin
    row  = rows_q[cnt_q*ROW_W +: ROW_W];
    c0   = SUM_W'(row[4*PROB_W-1:3*PROB_W]);
    c1   = c0 + SUM_W'(row[3*PROB_W-1:2*PROB_W]);
    c2   = c1 + SUM_W'(row[2*PROB_W-1:PROB_W]);
    r    = SUM_W'(lfsr_q[PROB_W-1:0]);
    pick = NUC_T;
    if      (r < c0) pick = NUC_A;
    else if (r < c1) pick = NUC_C;
    else if (r < c2) pick = NUC_G;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_q <= '0;
      cnt_q  <= '0;
      nucl_q <= '0;
    end else begin
      if ((state_q == IDLE) && in_valid) begin
        rows_q <= in_rows;
        cnt_q  <= '0;
      end else if (state_q == RUN) begin
        nucl_q[cnt_q*2 +: 2] <= pick;
        cnt_q                <= cnt_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_nucl  = nucl_q;

endmodule

// File: doc/nucl_sampler.md
# nucl_sampler

Downstream stage of the per-site row-select PE. Takes the 16 selected 40-bit transition-probability rows for one 16-site alignment chunk, draws one pseudo-random number per site, and picks each child nucleotide by inverse-CDF over the row. Emits a repacked 32-bit child alignment in the same 2-bit/site format the PE consumes, so results can feed the next branch.

## Interface
- `N_SITES`, 16: sites per chunk.
- `PROB_W`, 10: width of one probability (unsigned, scale 1024).
- `SEED`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.

- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_rows` valid.
- `in_ready`  out  1  block can accept `in_rows`.
- `in_rows`  in  N_SITES*4*PROB_W (640)  row i at [40i+39:40i]; within a row: A [39:30], C [29:20], G [19:10], T [9:0].
- `seed_load`  in  1  reload LFSR from `seed`.
- `seed`  in  16  new LFSR state.
- `out_valid`  out  1  `out_nucl` valid.
- `out_ready`  in  1  consumer accepts `out_nucl`.
- `out_nucl`  out  2*N_SITES (32)  site i at [2i+1:2i]; A=00, C=01, G=10, T=11.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `in_rows`, clear the site counter, go to RUN.
- **RUN**
  - Each cycle processes site `cnt`:
    - r = lfsr[9:0].
    - c0 = pA; c1 = pA+pC; c2 = pA+pC+pG. Sums are 12-bit, no truncation.
    - Result is A if r<c0, else C if r<c1, else G if r<c2, else T.
  - Write the result into `out_nucl[2cnt+1:2cnt]`, advance the LFSR once, then increment `cnt`.
  - After site N_SITES-1, go to DONE.
- **DONE**
  - `out_valid`=1; `out_nucl` is held stable.
  - On `out_ready`, go to IDLE.
- **LFSR**
  - 16-bit Galois, taps mask 16'hB400.
  - Advances only in RUN, exactly once per site.
- **Row probabilities**
  - Row sum below 1024: the shortfall falls to T.
  - Row sum above 1024: the ordering saturates. Earlier symbols win; no error is flagged.
  - All-zero row: always T.
- **seed_load**
  - Honoured only in IDLE.
  - If `seed_load` and `in_valid` arrive in the same cycle, both take effect. Site 0 uses the new seed.
  - Ignored in RUN and DONE.
  - A seed of 0 loads 16'hACE1.
- **Reset (any state, including mid-RUN)**
  - State goes to IDLE, `cnt`=0, `out_nucl`=0, `out_valid`=0, `busy`=0, `lfsr`=SEED.
  - `in_ready`=1 immediately after reset deasserts.
  - A partially sampled chunk is discarded.

## Timing
- `in_ready` = (state==IDLE). `out_valid` = (state==DONE). Both are registered-state decodes with no combinational path from inputs.
- Latency: input accepted at edge k; sites 0..15 are sampled at edges k+1..k+16; `out_valid` goes high after edge k+16.
- `out_ready` low holds DONE indefinitely. `in_ready` stays 0 and the LFSR is frozen.
- Throughput: at most one chunk per 18 cycles (1 accept + 16 RUN + 1 DONE handshake).
- The sampling compare and the 12-bit adds are single-cycle. Mux the row by `cnt` from the latched register.

## Structure
- Shared package `alisim_pkg` holds:
  - Nucleotide codes A/C/G/T (2-bit).
  - `PROB_W` and `ROW_W`=4*PROB_W.
  - The state enum {IDLE, RUN, DONE}.
  - LFSR taps 16'hB400 and default seed 16'hACE1.
- Sub-module `nucl_lfsr16`: ports `clk`, `reset_n`, `en`, `load`, `load_val`, `q[15:0]`. It contains the zero-seed substitution.
- The sampler holds the FSM, the row register, the counter, the compare chain and the output packing.

## Test plan
- **Reset:** assert `reset_n`=0 mid-RUN → next cycle `out_valid`=0, `out_nucl`=0, `busy`=0, `in_ready`=1. A chunk issued after release produces the same `out_nucl` as a chunk issued from cold reset.
- **All-zero rows:** `in_rows`=0 → after 16 cycles, `out_valid`=1 and `out_nucl`=32'hFFFF_FFFF.
- **Degenerate rows, C and A:**
  - Every row pA=0, pC=1023, pG=pT=0 → each site is C unless r==1023 (then T). Compare against a reference model LFSR seeded 16'hACE1.
  - Every row pA=1023, pC=1 → all sites A or C only, never G/T.
- **Random rows:** random row values and random seeds, 1000 chunks → `out_nucl` bit-exact against the golden model (same LFSR, same compare order). `out_valid` occurs exactly 16 cycles after acceptance.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE with `in_valid`=1 → `out_nucl` stable, `in_ready`=0, LFSR unchanged; the following chunk matches the model continuing from the frozen LFSR.
- **Seed handling:**
  - `seed_load` with `seed`=16'h1234 together with `in_valid` in IDLE, repeated twice on identical `in_rows` → identical `out_nucl`.
  - `seed_load` during RUN → ignored.
  - `seed`=0 → behaves as 16'hACE1.
